branch_predict_unit: RTL and testbench

//  - Parametrised successor to the EX-stage branch decision logic in the RV32 pipeline.
//  - Holds a direct-mapped BHT (2-bit saturating counters) and a BTB; predicts in IF from PCF.
//  - Resolves conditional branches in EX and raises a mispredict flush with the corrected PC.
//  - Trains the tables on every resolved branch. Sits between the IF PC mux and the EX hazard unit.

---
 rtl/branch_predict_unit_pkg.sv | 27 ++
 rtl/branch_predict_unit_compare.sv | 30 +++
 rtl/branch_predict_unit.sv | 103 ++++++++++
 tb/tb_branch_predict_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predictor: branch types, 2-bit counter states
// and the saturating counter update.
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        BR_NOBRANCH = 3'd0,
        BR_BEQ      = 3'd1,
        BR_BNE      = 3'd2,
        BR_BLT      = 3'd3,
        BR_BLTU     = 3'd4,
        BR_BGE      = 3'd5,
        BR_BGEU     = 3'd6
    } br_type_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == CTR_ST) ? c : c + 2'd1;
        else
            return (c == CTR_SNT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_compare.sv
// Combinational RV32 branch condition evaluation: returns the raw taken flag
// for the given branch type and forwarded operands.
module branch_compare
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            taken
);

    br_type_e bt;
    assign bt = br_type_e'(br_type);

    always_comb begin
        taken = 1'b0;
        case (bt)
            BR_BEQ:  taken = (op1 == op2);
            BR_BNE:  taken = (op1 != op2);
            BR_BLT:  taken = ($signed(op1) <  $signed(op2));
            BR_BGE:  taken = ($signed(op1) >= $signed(op2));
            BR_BLTU: taken = (op1 <  op2);
            BR_BGEU: taken = (op1 >= op2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BHT + BTB predictor with EX-stage resolve and mispredict redirect.
// Optional BRANCH_STATS_EN adds branch/mispredict event counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter int         TAG_W       = 8,
    parameter logic [1:0] CTR_INIT    = CTR_WNT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            ValidE,
    input  logic            StallE,
    input  logic [2:0]      BranchTypeE,
    input  logic [XLEN-1:0] Operand1E,
    input  logic [XLEN-1:0] Operand2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] TargetE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            BranchE,
    output logic            MispredE,
    output logic [XLEN-1:0] RedirectPCE
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     BranchCntE,
    output logic [31:0]     MispredCntE
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0][1:0]       ctr;
    logic [BHT_ENTRIES-1:0]            valid;
    logic [BHT_ENTRIES-1:0][TAG_W-1:0] tag;
    logic [BHT_ENTRIES-1:0][XLEN-1:0]  tgt;

    logic [IDX_W-1:0] fidx, eidx;
    logic [TAG_W-1:0] ftag, etag;
    logic             hit, active, cmp_taken, mis_raw;

    assign fidx = PCF[IDX_W+1:2];
    assign ftag = PCF[IDX_W+2 +: TAG_W];
    assign eidx = PCE[IDX_W+1:2];
    assign etag = PCE[IDX_W+2 +: TAG_W];

    // Byte offset and PC bits above the tag never take part in the lookup.
    logic unused_pcf;
    assign unused_pcf = ^{PCF[1:0], PCF[XLEN-1:IDX_W+2+TAG_W]};

    // Lookup reads pre-update table state; a same-cycle train is not bypassed.
    assign hit         = valid[fidx] && (tag[fidx] == ftag);
    assign PredTakenF  = hit && ctr[fidx][1];
    assign PredTargetF = PredTakenF ? tgt[fidx] : '0;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .br_type (BranchTypeE),
        .op1     (Operand1E),
        .op2     (Operand2E),
        .taken   (cmp_taken)
    );

    assign active      = ValidE && !StallE && (BranchTypeE != BR_NOBRANCH);
    assign BranchE     = active && cmp_taken;
    assign mis_raw     = (BranchE != PredTakenE) ||
                         (BranchE && PredTakenE && (PredTargetE != TargetE));
    assign MispredE    = active && mis_raw;
    assign RedirectPCE = !MispredE ? '0 : (BranchE ? TargetE : PCE + XLEN'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= CTR_INIT;
            valid <= '0;
            tag   <= '0;
            tgt   <= '0;
        end else if (active) begin
            ctr[eidx] <= ctr_next(ctr[eidx], BranchE);
            // Only taken branches allocate, so an alias is evicted on its next taken resolve.
            if (BranchE) begin
                valid[eidx] <= 1'b1;
                tag[eidx]   <= etag;
                tgt[eidx]   <= TargetE;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            BranchCntE  <= '0;
            MispredCntE <= '0;
        end else if (active) begin
            BranchCntE <= BranchCntE + 32'd1;
            if (MispredE) MispredCntE <= MispredCntE + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table for the resolve logic,
// hand sequences for lookup, training saturation, stall gating and async reset.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    logic        clk, rst_n;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ValidE, StallE;
    logic [2:0]  BranchTypeE;
    logic [31:0] Operand1E, Operand2E, PCE, TargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        BranchE, MispredE;
    logic [31:0] RedirectPCE;
`ifdef BRANCH_STATS_EN
    logic [31:0] BranchCntE, MispredCntE;
`endif

    branch_predict_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PredTakenF  (PredTakenF),
        .PredTargetF (PredTargetF),
        .ValidE      (ValidE),
        .StallE      (StallE),
        .BranchTypeE (BranchTypeE),
        .Operand1E   (Operand1E),
        .Operand2E   (Operand2E),
        .PCE         (PCE),
        .TargetE     (TargetE),
        .PredTakenE  (PredTakenE),
        .PredTargetE (PredTargetE),
        .BranchE     (BranchE),
        .MispredE    (MispredE),
        .RedirectPCE (RedirectPCE)
`ifdef BRANCH_STATS_EN
        ,
        .BranchCntE  (BranchCntE),
        .MispredCntE (MispredCntE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] bt, input logic [31:0] pce, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [31:0] tg, input logic pt,
                         input logic [31:0] ptg, input logic v, input logic s);
        BranchTypeE = bt;  PCE = pce;  Operand1E = op1;  Operand2E = op2;
        TargetE = tg;  PredTakenE = pt;  PredTargetE = ptg;  ValidE = v;  StallE = s;
    endtask

    task automatic idle();
        drive(BR_NOBRANCH, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // One resolved BEQ at pce, taken or not, trained on the following posedge.
    task automatic train(input logic [31:0] pce, input logic tk, input logic [31:0] tg);
        @(negedge clk);
        drive(BR_BEQ, pce, 32'd5, tk ? 32'd5 : 32'd6, tg, 1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1 idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  bt;
        logic [31:0] op1, op2, pce, tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        v, s;
        logic        eb, em;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int bad;
        rst_n = 1'b0;
        PCF   = 32'h100;
        idle();

        vecs[0]  = '{BR_BEQ,  32'd5,        32'd5,        32'h200,      32'h140, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h140};
        vecs[1]  = '{BR_BEQ,  32'd5,        32'd6,        32'h200,      32'h140, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{BR_BNE,  32'd5,        32'd6,        32'h204,      32'h300, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{BR_BNE,  32'd5,        32'd6,        32'h204,      32'h300, 1'b1, 32'h304, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300};
        vecs[4]  = '{BR_BLT,  32'hFFFFFFFF, 32'd1,        32'h208,      32'h400, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h400};
        vecs[5]  = '{BR_BLTU, 32'hFFFFFFFF, 32'd1,        32'h208,      32'h400, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20C};
        vecs[6]  = '{BR_BGE,  32'd1,        32'hFFFFFFFF, 32'h20C,      32'h500, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'h500};
        vecs[7]  = '{BR_BGEU, 32'd1,        32'hFFFFFFFF, 32'h20C,      32'h500, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{BR_BGE,  32'd7,        32'd7,        32'h210,      32'h600, 1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{BR_NOBRANCH, 32'd5,    32'd5,        32'h214,      32'h700, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{BR_BEQ,  32'd5,        32'd5,        32'h218,      32'h800, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{BR_BEQ,  32'd5,        32'd5,        32'h218,      32'h800, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{BR_BEQ,  32'd5,        32'd6,        32'hFFFFFFFC, 32'h900, 1'b1, 32'h900, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{BR_BLTU, 32'd1,        32'hFFFFFFFF, 32'h21C,      32'hA00, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 32'hA00};

        // Reset state: lookup empty, counters at weakly-not-taken.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_predtaken", {31'b0, PredTakenF}, 32'h0);
        chk("rst_predtarget", PredTargetF, 32'h0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (dut.ctr[i] !== 2'b01 || dut.valid[i] !== 1'b0) bad++;
        chk("rst_tables_bad_entries", bad, 0);

        // Resolve vectors.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].bt, vecs[i].pce, vecs[i].op1, vecs[i].op2, vecs[i].tgt,
                  vecs[i].pt, vecs[i].ptgt, vecs[i].v, vecs[i].s);
            #1;
            chk($sformatf("vec%0d_branch", i), {31'b0, BranchE}, {31'b0, vecs[i].eb});
            chk($sformatf("vec%0d_mispred", i), {31'b0, MispredE}, {31'b0, vecs[i].em});
            chk($sformatf("vec%0d_redirect", i), RedirectPCE, vecs[i].er);
        end
        @(negedge clk);
        idle();
        do_reset();

        // First taken BEQ at 0x100: lookup in the same cycle still sees the empty table.
        @(negedge clk);
        PCF = 32'h100;
        drive(BR_BEQ, 32'h100, 32'd5, 32'd5, 32'h140, 1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("seqB_branch", {31'b0, BranchE}, 32'h1);
        chk("seqB_mispred", {31'b0, MispredE}, 32'h1);
        chk("seqB_redirect", RedirectPCE, 32'h140);
        chk("seqB_nobypass", {31'b0, PredTakenF}, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("seqB_predtaken", {31'b0, PredTakenF}, 32'h1);
        chk("seqB_predtarget", PredTargetF, 32'h140);
        chk("seqB_ctr", {30'b0, dut.ctr[0]}, 32'h2);
        PCF = 32'h200;  // same index, different tag
        #1;
        chk("seqB_alias_miss", {31'b0, PredTakenF}, 32'h0);
        PCF = 32'h100;

        // Saturation up then down.
        repeat (4) train(32'h100, 1'b1, 32'h140);
        chk("sat_hi", {30'b0, dut.ctr[0]}, 32'h3);
        repeat (4) train(32'h100, 1'b0, 32'h140);
        chk("sat_lo", {30'b0, dut.ctr[0]}, 32'h0);
        #1;
        chk("sat_lo_predtaken", {31'b0, PredTakenF}, 32'h0);
        chk("sat_lo_valid_kept", {31'b0, dut.valid[0]}, 32'h1);

        // Stalled and invalid slots must not train.
        @(negedge clk);
        drive(BR_BEQ, 32'h104, 32'd5, 32'd5, 32'h180, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("stall_branch", {30'b0, BranchE, MispredE}, 32'h0);
        @(negedge clk);
        drive(BR_BEQ, 32'h104, 32'd5, 32'd5, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("invalid_branch", {30'b0, BranchE, MispredE}, 32'h0);
        @(negedge clk);
        idle();
        chk("gated_ctr", {30'b0, dut.ctr[1]}, 32'h1);
        chk("gated_valid", {31'b0, dut.valid[1]}, 32'h0);

        // Async reset mid-training takes effect without a clock edge.
        train(32'h104, 1'b1, 32'h180);
        @(negedge clk);
        drive(BR_BEQ, 32'h104, 32'd5, 32'd5, 32'h180, 1'b0, 32'h0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, |dut.valid}, 32'h0);
        chk("async_rst_ctr", {30'b0, dut.ctr[1]}, 32'h1);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

`ifdef BRANCH_STATS_EN
        do_reset();
        // 10 branches; the first three are taken but predicted not-taken.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(BR_BEQ, 32'h300 + 32'(i * 4), 32'd5, (i < 3) ? 32'd5 : 32'd6, 32'h800,
                  1'b0, 32'h0, 1'b1, 1'b0);
        end
        @(negedge clk);
        idle();
        chk("stats_branches", BranchCntE, 32'd10);
        chk("stats_mispreds", MispredCntE, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
